// File: rtl/hsi_msg_receiver_pkg.sv
// Shared definitions for the HSI message receiver: FSM encoding, reject
// reasons and CRC-16/CCITT constants (also used by the transmit side).
package hsi_msg_receiver_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RECV    = 3'd1;
    localparam state_t ST_CHECK   = 3'd2;
    localparam state_t ST_READ    = 3'd3;
    localparam state_t ST_DISCARD = 3'd4;

    localparam logic [1:0] FAIL_CRC   = 2'd0;
    localparam logic [1:0] FAIL_DEC   = 2'd1;
    localparam logic [1:0] FAIL_LONG  = 2'd2;
    localparam logic [1:0] FAIL_SHORT = 2'd3;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Per-message status collected while bytes arrive.
    typedef struct packed {
        logic dec_err;
        logic too_long;
        logic discard;
    } flags_t;

endpackage

// File: rtl/hsi_msg_receiver_if.sv
// Decoder-side strobes and payload readout port of the HSI message receiver.
interface hsi_msg_receiver_if #(
    parameter int MAX_PAYLOAD = 16
);
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

    logic [7:0]       d;
    logic             d_rdy;
    logic             dc_err;
    logic             msg_end;
    logic             rd_en;
    logic [7:0]       q;
    logic             q_valid;
    logic [LEN_W-1:0] msg_len;
    logic             msg_ok;
    logic             msg_fail;
    logic [1:0]       fail_code;
    logic             busy;

    modport master (
        output d, d_rdy, dc_err, msg_end, rd_en,
        input  q, q_valid, msg_len, msg_ok, msg_fail, fail_code, busy
    );

    modport slave (
        input  d, d_rdy, dc_err, msg_end, rd_en,
        output q, q_valid, msg_len, msg_ok, msg_fail, fail_code, busy
    );
endinterface

// File: rtl/hsi_crc16_byte.sv
// One-byte CRC-16/CCITT step: MSB first, unreflected, no final XOR.
module hsi_crc16_byte
    import hsi_msg_receiver_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  d,
    output logic [15:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[15] ? ((crc_next << 1) ^ CRC16_POLY) : (crc_next << 1);
        end
    end

endmodule

// File: rtl/hsi_msg_receiver.sv
// Collects decoded bytes into a buffer, verifies the trailing CRC-16 and
// presents the accepted payload for readout; rejects report a reason code.
module hsi_msg_receiver
    import hsi_msg_receiver_pkg::*;
#(
    parameter int MAX_PAYLOAD = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    hsi_msg_receiver_if.slave  bus
);

    localparam int DEPTH = MAX_PAYLOAD + 2;   // payload plus two CRC bytes
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(3);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] rd_ptr, rd_ptr_nx;
    logic [LEN_W-1:0] msg_len, msg_len_nx;
    logic [15:0]      crc, crc_nx, crc_base, crc_upd;
    flags_t           flags, flags_nx;

    logic [7:0]       buffer [DEPTH];
    logic             wr_en;
    logic [CNT_W-1:0] wr_addr;

    logic             verdict_ok;
    logic [1:0]       verdict_code;
    logic             rd_done;

    // The first byte of a message always starts from a fresh CRC.
    assign crc_base = (state == ST_IDLE) ? CRC16_INIT : crc;

    hsi_crc16_byte u_crc (
        .crc      (crc_base),
        .d        (bus.d),
        .crc_next (crc_upd)
    );

    always_comb begin
        verdict_code = FAIL_CRC;
        if (flags.dec_err)
            verdict_code = FAIL_DEC;
        else if (flags.too_long)
            verdict_code = FAIL_LONG;
        else if (cnt < CNT_MIN)
            verdict_code = FAIL_SHORT;
    end

    assign verdict_ok = !flags.dec_err && !flags.too_long && (cnt >= CNT_MIN) && (crc == 16'h0000);
    assign rd_done    = (rd_ptr == msg_len);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nx   = state;
        cnt_nx     = cnt;
        rd_ptr_nx  = rd_ptr;
        msg_len_nx = msg_len;
        crc_nx     = crc;
        flags_nx   = flags;
        wr_en      = 1'b0;
        wr_addr    = cnt;

        case (state)
            ST_IDLE: begin
                if (bus.d_rdy) begin
                    wr_en            = 1'b1;
                    wr_addr          = '0;
                    cnt_nx           = CNT_W'(1);
                    crc_nx           = crc_upd;
                    flags_nx         = '0;
                    flags_nx.dec_err = bus.dc_err;
                    state_nx         = bus.msg_end ? ST_CHECK : ST_RECV;
                end
            end
            ST_RECV: begin
                if (bus.d_rdy) begin
                    if (cnt == CNT_FULL) begin
                        flags_nx.too_long = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        cnt_nx = cnt + CNT_W'(1);
                        crc_nx = crc_upd;
                    end
                end
                if (bus.dc_err)
                    flags_nx.dec_err = 1'b1;
                if (bus.msg_end)
                    state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                if (verdict_ok) begin
                    msg_len_nx       = LEN_W'(cnt - CNT_W'(2));
                    rd_ptr_nx        = '0;
                    flags_nx.discard = 1'b0;
                    state_nx         = ST_READ;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_READ: begin
                if (bus.rd_en && !rd_done)
                    rd_ptr_nx = rd_ptr + LEN_W'(1);
                // A message that starts during readout is dropped; remember
                // whether it is still in flight when the readout finishes.
                flags_nx.discard = (flags.discard | bus.d_rdy) & ~bus.msg_end;
                if (rd_done)
                    state_nx = flags_nx.discard ? ST_DISCARD : ST_IDLE;
            end
            ST_DISCARD: begin
                if (bus.msg_end)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rd_ptr  <= '0;
            msg_len <= '0;
            crc     <= CRC16_INIT;
            flags   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rd_ptr  <= rd_ptr_nx;
            msg_len <= msg_len_nx;
            crc     <= crc_nx;
            flags   <= flags_nx;
        end
    end

    // NOTE: the byte buffer has no reset; its contents are never observed before being written.
    always_ff @(posedge clk) begin
        if (wr_en)
            buffer[wr_addr] <= bus.d;
    end

    assign bus.q_valid   = (state == ST_READ) && !rd_done;
    assign bus.q         = bus.q_valid ? buffer[rd_ptr] : 8'h00;
    assign bus.msg_len   = msg_len;
    assign bus.msg_ok    = (state == ST_CHECK) && verdict_ok;
    assign bus.msg_fail  = (state == ST_CHECK) && !verdict_ok;
    assign bus.fail_code = bus.msg_fail ? verdict_code : FAIL_CRC;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: doc/hsi_msg_receiver.md
HSI_MSG_RECEIVER -- requirements
Module: hsi_msg_receiver

Interface
REQ-001 Parameter: MAX_PAYLOAD, default 16, maximum payload bytes per message (CRC bytes excluded).
REQ-002 clk  input  1  system clock.
REQ-003 n_rst  input  1  reset: asynchronous, active-low.
REQ-004 d  input  8  decoded byte from the line decoder.
REQ-005 d_rdy  input  1  one-cycle strobe, d valid.
REQ-006 dc_err  input  1  one-cycle strobe, decoder symbol/parity error.
REQ-007 msg_end  input  1  one-cycle strobe, end-of-message gap detected by the decoder.
REQ-008 rd_en  input  1  payload read request, honoured only when q_valid=1.
REQ-009 q  output  8  payload byte at read pointer.
REQ-010 q_valid  output  1  payload available to read (READ state, unread bytes remain).
REQ-011 msg_len  output  5  payload length of the held message (width = clog2(MAX_PAYLOAD+1)).
REQ-012 msg_ok  output  1  one-cycle pulse, message accepted, CRC good.
REQ-013 msg_fail  output  1  one-cycle pulse, message rejected.
REQ-014 fail_code  output  2  reason, valid with msg_fail: 0 CRC, 1 decoder error, 2 too long, 3 too short.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, RECV, CHECK, READ, DISCARD.
REQ-017 IDLE: d_rdy -> store d at buffer[0], cnt=1, CRC register updated, -> RECV; msg_end alone ignored.
REQ-018 RECV: each d_rdy stores d at buffer[cnt], cnt++, CRC updated with d, same cycle.
REQ-019 CRC: CRC-16/CCITT, poly 0x1021, init 0xFFFF, MSB first, no reflection, no final XOR, one byte per clock; CRC register re-initialised to 0xFFFF on entry to RECV from IDLE.
REQ-020 Sender appends CRC high byte first; message good iff CRC register = 0x0000 after last byte.
REQ-021 RECV: cnt would exceed MAX_PAYLOAD+2 -> byte dropped, too-long flag set, continue until msg_end.
REQ-022 RECV: dc_err -> error flag set, stay in RECV until msg_end.
REQ-023 d_rdy and msg_end in same cycle: byte stored first, then -> CHECK.
REQ-024 dc_err and msg_end in same cycle: error flag counts for this message.
REQ-025 RECV + msg_end -> CHECK (1 cycle). Priority: decoder error > too long > too short (cnt<3) > CRC.
REQ-026 CHECK good: msg_ok pulse, msg_len=cnt-2, read pointer=0, -> READ; failed: msg_fail pulse with fail_code, -> IDLE.
REQ-027 msg_ok/msg_fail asserted in the cycle after msg_end (latency 1 clock).
REQ-028 READ: q=buffer[rd_ptr] combinational from register file; rd_en with q_valid -> rd_ptr++; rd_ptr=msg_len -> IDLE next cycle, q_valid=0.
REQ-029 READ: incoming d_rdy -> DISCARD flag; bytes dropped, held message untouched; after readout, if remainder of new message still arriving, -> DISCARD until msg_end, then msg_fail code 1 not issued (silent drop) -> IDLE.
REQ-030 rd_en while q_valid=0 ignored; d_rdy in CHECK ignored.
REQ-031 msg_len holds value until next CHECK.

Reset
REQ-032 n_rst low: state=IDLE, cnt=0, rd_ptr=0, CRC=0xFFFF, flags=0, q=0x00, q_valid=0, msg_len=0, msg_ok=0, msg_fail=0, fail_code=0, busy=0; buffer contents undefined.
REQ-033 Reset mid-message discards it; no pulse issued after release.

Structure
REQ-034 Shared package holds: FSM state encoding, fail_code constants, CRC16 polynomial 0x1021 and init 0xFFFF.
REQ-035 One sub-module: hsi_crc16_byte (combinational next-CRC from crc[15:0], d[7:0]), reusable by the transmit side.

Verification
REQ-036 Bytes 0x31..0x39 ("123456789") + 0x29,0xB1, msg_end -> msg_ok, msg_len=9, read returns 0x31..0x39 in order.
REQ-037 Same with last CRC byte 0xB0 -> msg_fail, fail_code=0, busy=0 next cycle.
REQ-038 dc_err on byte 3, then msg_end -> msg_fail, fail_code=1.
REQ-039 MAX_PAYLOAD+3 bytes -> fail_code=2; single byte + msg_end -> fail_code=3.
REQ-040 Last byte d_rdy coincident with msg_end -> accepted, msg_ok one cycle later; n_rst pulse mid-message -> no pulse, IDLE.
REQ-041 New message arrives during READ -> held payload read intact, new message dropped, no msg_ok.
